// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Optional error reporting (rsp_err, err_seen) enabled by ALU_SHARE_ARB_ERR_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_control,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_control,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_branch
`ifdef ALU_SHARE_ARB_ERR_EN
    ,
    output logic             rsp_err,
    output logic             err_seen
`endif
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state, w_next;
    logic             r_last_grant;
    logic             r_id;
    logic [3:0]       r_ctrl;
    logic [WIDTH-1:0] r_a, r_b;

    logic             w_gnt1, w_accept;
    logic [WIDTH-1:0] w_y, w_diff;
    logic             w_br;
    logic [SHW-1:0]   w_sh;

    // Contention goes to the port that did not win last; a lone requester always wins.
    assign w_gnt1     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid) && !reset;
    assign req0_ready = w_accept && !w_gnt1;
    assign req1_ready = w_accept && w_gnt1;
    assign rsp_valid  = (r_state == S_RESP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_ctrl       <= '0;
            r_a          <= '0;
            r_b          <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt1;
            r_id         <= w_gnt1;
            r_ctrl       <= w_gnt1 ? req1_control : req0_control;
            r_a          <= w_gnt1 ? req1_a : req0_a;
            r_b          <= w_gnt1 ? req1_b : req0_b;
        end
    end

    assign w_diff = r_a - r_b;
    assign w_sh   = r_b[SHW-1:0];

    always_comb begin
        w_y  = '0;
        w_br = 1'b0;
        case (r_ctrl)
            4'b0000: w_y = r_a + r_b;
            4'b0001: begin w_y = w_diff; w_br = (w_diff == '0); end
            4'b0010: w_y = r_a & r_b;
            4'b0011: w_y = r_a | r_b;
            4'b0100: w_y = r_a << w_sh;
            4'b0101: w_y = WIDTH'($signed(r_a) < $signed(r_b));
            4'b0110: w_y = WIDTH'(r_a < r_b);
            4'b0111: w_y = r_a ^ r_b;
            4'b1000: w_y = $unsigned($signed(r_a) >>> w_sh);
            4'b1001: w_y = r_a >> w_sh;
            4'b1010: w_y = WIDTH'($signed(r_a) >= $signed(r_b));
            4'b1011: w_y = WIDTH'(r_a >= r_b);
            4'b1100: begin w_y = w_diff; w_br = (w_diff != '0); end
            default: begin w_y = '0; w_br = 1'b0; end
        endcase
        // Compare ops report their outcome on both y[0] and branch.
        if (r_ctrl inside {4'b0101, 4'b0110, 4'b1010, 4'b1011}) w_br = w_y[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_y      <= '0;
            rsp_branch <= 1'b0;
            rsp_id     <= 1'b0;
        end else if (r_state == S_EXEC) begin
            rsp_y      <= w_y;
            rsp_branch <= w_br;
            rsp_id     <= r_id;
        end
    end

`ifdef ALU_SHARE_ARB_ERR_EN
    logic w_illegal;
    assign w_illegal = (r_ctrl >= 4'b1101);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err  <= 1'b0;
            err_seen <= 1'b0;
        end else if (r_state == S_EXEC) begin
            rsp_err  <= w_illegal;
            if (w_illegal) err_seen <= 1'b1;
        end
    end
`endif

endmodule
